i2s_mic_ctrl: RTL
=================

Name: i2s_mic_ctrl

Overview:
- Master-mode sequencer for the 24-bit I2S microphone capture path.
- Divides the system clock to generate SCK and WS for the microphone and the capture block.
- Runs the microphone power-up sequence: clock-run startup wait, then discard of the first settling samples.
- Forwards captured samples through a one-entry ready/valid buffer to downstream DSP, flagging overruns.

Parameters:
SCK_DIV_HALF, 8, clk cycles per SCK half-period (>=2); SCK period = 2*SCK_DIV_HALF clk
BITS_PER_SLOT, 32, SCK cycles per WS half (one channel slot); frame = 2*BITS_PER_SLOT SCK
STARTUP_CYCLES, 1024, clk cycles SCK must run before samples are considered (>=1)
DISCARD_SAMPLES, 16, cap_valid_i pulses dropped after startup (0 allowed = no discard)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  level; high requests streaming, low requests stop
sck_o  out  1  I2S bit clock to mic and capture block
ws_o  out  1  I2S word select (0 = left slot, 1 = right slot)
cap_data_i  in  24  sample from capture block
cap_valid_i  in  1  one-cycle strobe, cap_data_i valid
sample_o  out  24  forwarded sample
sample_valid_o  out  1  buffer holds a sample
sample_ready_i  in  1  downstream accepts
overrun_o  out  1  one-cycle pulse, sample dropped
overrun_cnt_o  out  8  saturating count of dropped samples
running_o  out  1  high only in RUN
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE; sck_o=0, ws_o=0, sample_o=0, sample_valid_o=0, overrun_o=0, overrun_cnt_o=0, running_o=0, busy_o=0; all counters 0.
- States: IDLE, STARTUP, DISCARD, RUN, STOP.
- Clock generator, active in every state except IDLE:
  - div_cnt counts 0..SCK_DIV_HALF-1; on wrap sck_o toggles.
  - On each SCK falling toggle, bit_cnt advances 0..2*BITS_PER_SLOT-1 and wraps.
  - ws_o = (bit_cnt >= BITS_PER_SLOT), registered so it changes with the SCK falling edge.
  - IDLE holds sck_o=0, ws_o=0, div_cnt=0, bit_cnt=0.
- First SCK rising edge occurs SCK_DIV_HALF clk after leaving IDLE.
- Transitions:
  - IDLE -> STARTUP when enable_i=1.
  - STARTUP counts STARTUP_CYCLES clk, then -> DISCARD, or -> RUN if DISCARD_SAMPLES=0.
  - DISCARD counts cap_valid_i pulses. The pulse reaching DISCARD_SAMPLES is itself discarded; next cycle -> RUN.
  - RUN -> STOP when enable_i=0.
  - STOP holds until bit_cnt wraps to 0 on a SCK falling edge (frame boundary), then -> IDLE. This happens even if enable_i re-rises; from IDLE, enable_i=1 restarts at STARTUP the next cycle.
  - enable_i=0 in STARTUP or DISCARD -> IDLE immediately; counters cleared.
- Forwarding: cap_valid_i is accepted only in RUN and STOP; ignored in IDLE, STARTUP, DISCARD.
  - Accepted sample loads sample_o and sets sample_valid_o on the next clk (latency 1).
  - sample_valid_o and sample_o hold stable until sample_ready_i=1. Handshake completes in a cycle where both are high.
  - Simultaneous accept and new cap_valid_i: new sample loads, valid stays 1, no overrun.
  - Buffer full, no ready, cap_valid_i=1: new sample dropped, old kept, overrun_o pulses 1 cycle, overrun_cnt_o += 1 saturating at 255.
  - overrun_cnt_o clears only on reset or on the IDLE->STARTUP transition.
  - A buffered sample stays valid across STOP->IDLE until taken.
- running_o and busy_o are registered decodes of the state.

Test Plan:
- Params SCK_DIV_HALF=2, BITS_PER_SLOT=32, STARTUP_CYCLES=20, DISCARD_SAMPLES=2. Raise enable_i -> sck_o period 4 clk; ws_o toggles every 128 clk, changing only when sck_o falls; busy_o=1, running_o=0.
- Same params, cap_valid_i with data 0x000001, 0x000002, 0x000003 after STARTUP (ready=1) -> first two dropped; running_o rises after the second; sample_o=0x000003 with sample_valid_o 1 clk after its strobe.
- RUN, sample_ready_i=0, three strobes 0xAAAAAA, 0xBBBBBB, 0xCCCCCC -> sample_o stays 0xAAAAAA; overrun_o pulses twice; overrun_cnt_o=2. Then assert ready with a new strobe the same cycle -> loaded, no overrun.
- Drop enable_i mid-right-slot in RUN -> STOP; SCK keeps running until bit_cnt wraps; then sck_o=0, ws_o=0, busy_o=0. Re-raise enable_i during STOP -> still goes IDLE, then STARTUP next cycle, overrun_cnt_o cleared.
- Drop enable_i during STARTUP at cycle 10 -> IDLE next cycle; re-enable -> full 20-cycle STARTUP repeats.
- Pulse rst_ni low asynchronously mid-RUN with a buffered sample -> all outputs at reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/i2s_mic_ctrl.sv
// Master-mode I2S microphone sequencer: SCK/WS generation, power-up startup/discard,
// and a one-entry ready/valid sample buffer with overrun reporting.
module i2s_mic_ctrl #(
  parameter int SCK_DIV_HALF    = 8,
  parameter int BITS_PER_SLOT   = 32,
  parameter int STARTUP_CYCLES  = 1024,
  parameter int DISCARD_SAMPLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic        sck_o,
  output logic        ws_o,
  input  logic [23:0] cap_data_i,
  input  logic        cap_valid_i,
  output logic [23:0] sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        overrun_o,
  output logic [7:0]  overrun_cnt_o,
  output logic        running_o,
  output logic        busy_o
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STARTUP = 3'd1;
  localparam logic [2:0] S_DISCARD = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;

  localparam int DIV_W = $clog2(SCK_DIV_HALF);
  localparam int BIT_W = $clog2(2 * BITS_PER_SLOT);
  localparam int STU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int DSC_W = $clog2(DISCARD_SAMPLES + 2);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BITS_PER_SLOT - 1);
  localparam logic [BIT_W-1:0] WS_START = BIT_W'(BITS_PER_SLOT);
  localparam logic [STU_W-1:0] STU_LAST = STU_W'(STARTUP_CYCLES - 1);
  localparam logic [DSC_W-1:0] DSC_LAST = DSC_W'((DISCARD_SAMPLES == 0) ? 0 : DISCARD_SAMPLES - 1);
  localparam logic [2:0]       POST_STARTUP = (DISCARD_SAMPLES == 0) ? S_RUN : S_DISCARD;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sck_q, sck_d;
  logic             ws_q, ws_d;
  logic [STU_W-1:0] stu_q, stu_d;
  logic [DSC_W-1:0] dsc_q, dsc_d;
  logic [23:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;
  logic             running_q, running_d;
  logic             busy_q, busy_d;

  logic sck_fall, frame_end, accept, take;

  always_comb begin
    sck_fall  = (state_q != S_IDLE) && (div_q == DIV_LAST) && sck_q;
    frame_end = sck_fall && (bit_q == BIT_LAST);

    state_d = state_q;
    stu_d   = stu_q;
    dsc_d   = dsc_q;
    case (state_q)
      S_IDLE: begin
        stu_d = '0;
        dsc_d = '0;
        if (enable_i) state_d = S_STARTUP;
      end
      S_STARTUP: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          stu_d   = '0;
        end else if (stu_q == STU_LAST) begin
          state_d = POST_STARTUP;
          stu_d   = '0;
        end else begin
          stu_d = stu_q + 1'b1;
        end
      end
      S_DISCARD: begin
        if (!enable_i) begin
          state_d = S_IDLE;
          dsc_d   = '0;
        end else if (cap_valid_i) begin
          if (dsc_q == DSC_LAST) begin
            state_d = S_RUN;
            dsc_d   = '0;
          end else begin
            dsc_d = dsc_q + 1'b1;
          end
        end
      end
      S_RUN:   if (!enable_i) state_d = S_STOP;
      // Stopping only on a frame boundary keeps the mic from seeing a truncated frame.
      S_STOP:  if (frame_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    div_d = div_q;
    sck_d = sck_q;
    bit_d = bit_q;
    ws_d  = ws_q;
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      div_d = '0;
      sck_d = 1'b0;
      bit_d = '0;
      ws_d  = 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      sck_d = ~sck_q;
      if (sck_q) begin
        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
        ws_d  = (bit_d >= WS_START);
      end
    end else begin
      div_d = div_q + 1'b1;
    end

    accept    = cap_valid_i && (state_q == S_RUN || state_q == S_STOP);
    take      = valid_q && sample_ready_i;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    ovr_cnt_d = ovr_cnt_q;
    if (state_q == S_IDLE && state_d == S_STARTUP) ovr_cnt_d = '0;
    if (take) valid_d = 1'b0;
    if (accept) begin
      if (!valid_q || take) begin
        data_d  = cap_data_i;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
        if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end

    running_d = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      stu_q     <= '0;
      dsc_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      stu_q     <= stu_d;
      dsc_q     <= dsc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      running_q <= running_d;
      busy_q    <= busy_d;
    end
  end

  assign sck_o          = sck_q;
  assign ws_o           = ws_q;
  assign sample_o       = data_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = ovr_q;
  assign overrun_cnt_o  = ovr_cnt_q;
  assign running_o      = running_q;
  assign busy_o         = busy_q;
endmodule
